// File: rtl/mdu_issue_ctrl.sv
// Issue/retire controller for the fixed-latency M-extension ALU: tracks in-flight
// destinations, flags RAW hazards to decode and forms the register-file writeback.
module mdu_issue_ctrl #(
  parameter int LATENCY = 6
) (
  input  logic        clk,
  input  logic        rstd,
  input  logic        issue_valid,
  input  logic [5:0]  issue_alucode,
  input  logic [4:0]  issue_rd,
  input  logic [31:0] issue_op1,
  input  logic [31:0] issue_op2,
  output logic        issue_ready,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  output logic        raw_hazard,
  output logic        mc_start,
  output logic [5:0]  mc_alucode,
  output logic [31:0] mc_op1,
  output logic [31:0] mc_op2,
  input  logic [31:0] mc_result,
  input  logic        mc_done,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic [2:0]  inflight,
  output logic        err
);

  localparam int GW = $clog2(LATENCY + 1);

  logic [LATENCY-1:0]      r_v;
  logic [LATENCY-1:0][4:0] r_rd;
  logic [LATENCY-1:0][5:0] r_code;
  logic [GW-1:0]           r_guard;
  logic                    r_err;

  logic       w_retire;
  logic [4:0] w_ret_rd;
  logic [5:0] w_ret_code;
  logic       w_accept;
  logic       w_hazard;
  logic [2:0] w_count;

  assign w_retire   = r_v[LATENCY-1];
  assign w_ret_rd   = r_rd[LATENCY-1];
  assign w_ret_code = r_code[LATENCY-1];

  // alucode is shared with the retiring op, so no issue can happen while one retires
  assign issue_ready = !w_retire;
  assign w_accept    = issue_valid & !w_retire;
  assign mc_start    = w_accept;
  assign mc_op1      = issue_op1;
  assign mc_op2      = issue_op2;
  assign mc_alucode  = w_retire ? w_ret_code : issue_alucode;

  assign wb_valid = w_retire & (w_ret_rd != 5'd0);
  assign wb_rd    = wb_valid ? w_ret_rd : 5'd0;
  assign wb_data  = wb_valid ? mc_result : 32'd0;

  always_ff @(posedge clk) begin
    if (!rstd) begin
      r_v <= '0;
    end else begin
      r_v <= {r_v[LATENCY-2:0], w_accept};
    end
  end

  // Payload fields need no reset; they are qualified by the valid bits
  always_ff @(posedge clk) begin
    r_rd   <= {r_rd[LATENCY-2:0], issue_rd};
    r_code <= {r_code[LATENCY-2:0], issue_alucode};
  end

  always_comb begin
    w_hazard = 1'b0;
    w_count  = 3'd0;
    for (int i = 0; i < LATENCY; i++) begin
      w_count = w_count + {2'b00, r_v[i]};
      if (r_v[i] && (r_rd[i] != 5'd0) && ((r_rd[i] == dec_rs1) || (r_rd[i] == dec_rs2))) begin
        w_hazard = 1'b1;
      end
    end
  end

  assign raw_hazard = w_hazard;
  assign inflight   = w_count;

  // Guard window hides done pulses of ops the ALU was still carrying across a reset
  always_ff @(posedge clk) begin
    if (!rstd) begin
      r_guard <= GW'(LATENCY);
      r_err   <= 1'b0;
    end else begin
      if (r_guard != '0) begin
        r_guard <= r_guard - 1'b1;
      end
      if ((r_guard == '0) && (mc_done != w_retire)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err = r_err;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Directed bench for mdu_issue_ctrl with a behavioural 6-stage M-ext ALU and a
// writeback scoreboard checked by an independent monitor.
module tb_mdu_issue_ctrl;

  localparam logic [5:0] ALU_ADD    = 6'd0;
  localparam logic [5:0] ALU_MUL    = 6'd24;
  localparam logic [5:0] ALU_MULH   = 6'd25;
  localparam logic [5:0] ALU_MULHSU = 6'd26;
  localparam logic [5:0] ALU_MULHU  = 6'd27;
  localparam logic [5:0] ALU_DIV    = 6'd28;
  localparam logic [5:0] ALU_DIVU   = 6'd29;
  localparam logic [5:0] ALU_REM    = 6'd30;
  localparam logic [5:0] ALU_REMU   = 6'd31;

  logic        clk = 1'b0;
  logic        rstd;
  logic        issue_valid;
  logic [5:0]  issue_alucode;
  logic [4:0]  issue_rd;
  logic [31:0] issue_op1, issue_op2;
  logic        issue_ready;
  logic [4:0]  dec_rs1, dec_rs2;
  logic        raw_hazard;
  logic        mc_start;
  logic [5:0]  mc_alucode;
  logic [31:0] mc_op1, mc_op2;
  logic [31:0] mc_result;
  logic        mc_done;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [2:0]  inflight;
  logic        err;

  int vectors     = 0;
  int miscompares = 0;
  logic started   = 1'b0;
  logic force_done = 1'b0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;
  wb_t sbq[$];

  always #5 clk = ~clk;

  mdu_issue_ctrl #(.LATENCY(6)) dut (
    .clk(clk), .rstd(rstd),
    .issue_valid(issue_valid), .issue_alucode(issue_alucode), .issue_rd(issue_rd),
    .issue_op1(issue_op1), .issue_op2(issue_op2), .issue_ready(issue_ready),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .raw_hazard(raw_hazard),
    .mc_start(mc_start), .mc_alucode(mc_alucode), .mc_op1(mc_op1), .mc_op2(mc_op2),
    .mc_result(mc_result), .mc_done(mc_done),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .inflight(inflight), .err(err)
  );

  // ALU model: operands travel 6 stages; the result half is picked with the
  // alucode presented in the done cycle, as the real ALU does. No reset.
  logic [5:0]  alu_v = '0;
  logic [31:0] alu_a [6];
  logic [31:0] alu_b [6];

  always @(posedge clk) begin
    for (int i = 5; i > 0; i--) begin
      alu_v[i] <= alu_v[i-1];
      alu_a[i] <= alu_a[i-1];
      alu_b[i] <= alu_b[i-1];
    end
    alu_v[0] <= mc_start;
    alu_a[0] <= mc_op1;
    alu_b[0] <= mc_op2;
  end

  function automatic logic [31:0] alu_f(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] ps;
    logic [63:0] pu;
    logic signed [63:0] psu;
    ps  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    pu  = {32'd0, a} * {32'd0, b};
    psu = $signed({{32{a[31]}}, a}) * $signed({32'd0, b});
    case (code)
      ALU_MUL:    return ps[31:0];
      ALU_MULH:   return ps[63:32];
      ALU_MULHSU: return psu[63:32];
      ALU_MULHU:  return pu[63:32];
      ALU_DIV:    return (b == 0) ? 32'hFFFF_FFFF : 32'($signed(a) / $signed(b));
      ALU_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      ALU_REM:    return (b == 0) ? a : 32'($signed(a) % $signed(b));
      ALU_REMU:   return (b == 0) ? a : a % b;
      default:    return 32'd0;
    endcase
  endfunction

  assign mc_done   = alu_v[5] | force_done;
  assign mc_result = alu_f(mc_alucode, alu_a[5], alu_b[5]);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every writeback must match the head of the scoreboard
  always @(negedge clk) begin
    if (started && wb_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL wb_unexpected: got rd=%0d data=0x%08h, expected no writeback", wb_rd, wb_data);
      end else begin
        wb_t e;
        e = sbq.pop_front();
        chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
        chk("wb_data", wb_data, e.data);
        $display("wb rd=%0d data=0x%08h", wb_rd, wb_data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    issue_valid   = 1'b0;
    issue_alucode = ALU_ADD;
    issue_rd      = 5'd0;
    issue_op1     = 32'd0;
    issue_op2     = 32'd0;
  endtask

  task automatic issue(input logic [5:0] code, input logic [4:0] rd, input logic [31:0] a,
                       input logic [31:0] b, input logic push, input logic [31:0] exp);
    wb_t e;
    issue_valid   = 1'b1;
    issue_alucode = code;
    issue_rd      = rd;
    issue_op1     = a;
    issue_op2     = b;
    if (push) begin
      e.rd   = rd;
      e.data = exp;
      sbq.push_back(e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstd = 1'b0;
    dec_rs1 = 5'd0;
    dec_rs2 = 5'd0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    rstd = 1'b1;
    started = 1'b1;
    settle();
    chk("rst_inflight", 32'(inflight), 32'd0);
    chk("rst_ready", 32'(issue_ready), 32'd1);
    chk("rst_hazard", 32'(raw_hazard), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // Single MUL 7*6 -> rd5
    tick(); issue(ALU_MUL, 5'd5, 32'd7, 32'd6, 1'b1, 32'd42); settle();
    chk("t1_start", 32'(mc_start), 32'd1);
    chk("t1_ready", 32'(issue_ready), 32'd1);
    tick(); idle(); settle();
    chk("t1_inflight", 32'(inflight), 32'd1);
    repeat (4) tick();
    tick(); settle();
    chk("t1_alucode", 32'(mc_alucode), 32'(ALU_MUL));
    chk("t1_wb_valid", 32'(wb_valid), 32'd1);
    chk("t1_wb_rd", 32'(wb_rd), 32'd5);
    chk("t1_wb_data", wb_data, 32'd42);
    tick(); settle();
    chk("t1_inflight_end", 32'(inflight), 32'd0);

    // MULH -1*2 with ADD held on the issue port during retire
    tick(); issue(ALU_MULH, 5'd3, 32'hFFFF_FFFF, 32'd2, 1'b1, 32'hFFFF_FFFF);
    tick(); idle(); issue_alucode = ALU_ADD;
    repeat (4) tick();
    tick(); settle();
    chk("t2_alucode", 32'(mc_alucode), 32'(ALU_MULH));
    chk("t2_wb_data", wb_data, 32'hFFFF_FFFF);
    tick();

    // Back-to-back issues rd1..6 with issue_valid held through the retire window
    for (int i = 1; i <= 6; i++) begin
      tick(); issue(ALU_MUL, 5'(i), 32'(i), 32'd10, 1'b1, 32'(i * 10));
    end
    settle();
    chk("t3_inflight5", 32'(inflight), 32'd5);
    for (int j = 6; j <= 11; j++) begin
      tick(); issue(ALU_MUL, 5'd7, 32'd1, 32'd1, 1'b0, 32'd0); settle();
      chk("t3_ready_retire", 32'(issue_ready), 32'd0);
      chk("t3_start_retire", 32'(mc_start), 32'd0);
      if (j == 6) chk("t3_inflight_full", 32'(inflight), 32'd6);
    end
    tick(); idle(); settle();
    chk("t3_ready_after", 32'(issue_ready), 32'd1);
    chk("t3_inflight_end", 32'(inflight), 32'd0);
    chk("t3_err", 32'(err), 32'd0);

    // RAW hazard on rs1 for DIV rd9
    tick(); dec_rs1 = 5'd9; issue(ALU_DIV, 5'd9, 32'd100, 32'd7, 1'b1, 32'd14); settle();
    chk("t4_hazard_issue", 32'(raw_hazard), 32'd0);
    for (int k = 1; k <= 6; k++) begin
      tick(); idle(); settle();
      chk("t4_hazard_inflight", 32'(raw_hazard), 32'd1);
    end
    tick(); settle();
    chk("t4_hazard_clear", 32'(raw_hazard), 32'd0);

    // rd0 op: no hazard, no writeback
    tick(); dec_rs1 = 5'd0; dec_rs2 = 5'd0; issue(ALU_DIVU, 5'd0, 32'd50, 32'd5, 1'b0, 32'd0);
    for (int k = 1; k <= 6; k++) begin
      tick(); idle(); settle();
      chk("t4_rd0_hazard", 32'(raw_hazard), 32'd0);
    end
    chk("t4_rd0_wb_valid", 32'(wb_valid), 32'd0);
    chk("t4_rd0_wb_rd", 32'(wb_rd), 32'd0);
    chk("t4_rd0_wb_data", wb_data, 32'd0);

    // Hazard on rs2 for REMU rd12
    tick(); dec_rs2 = 5'd12; issue(ALU_REMU, 5'd12, 32'd100, 32'd7, 1'b1, 32'd2);
    tick(); idle(); settle();
    chk("t4_hazard_rs2", 32'(raw_hazard), 32'd1);
    repeat (5) tick();
    tick(); settle();
    chk("t4_hazard_rs2_clear", 32'(raw_hazard), 32'd0);
    dec_rs2 = 5'd0;

    // Reset with an op in flight; the ALU keeps delivering its done pulse
    tick(); dec_rs1 = 5'd7; issue(ALU_MUL, 5'd7, 32'd3, 32'd3, 1'b0, 32'd0);
    tick(); idle();
    tick();
    tick(); rstd = 1'b0;
    tick(); rstd = 1'b1; issue(ALU_MUL, 5'd0, 32'd1, 32'd1, 1'b0, 32'd0); settle();
    chk("t5_inflight", 32'(inflight), 32'd0);
    chk("t5_ready", 32'(issue_ready), 32'd1);
    chk("t5_hazard", 32'(raw_hazard), 32'd0);
    chk("t5_wb_valid", 32'(wb_valid), 32'd0);
    chk("t5_start", 32'(mc_start), 32'd1);
    tick(); idle();
    tick(); settle();
    chk("t5_stale_done_wb", 32'(wb_valid), 32'd0);
    repeat (6) tick();
    settle();
    chk("t5_err", 32'(err), 32'd0);
    dec_rs1 = 5'd0;

    // Spurious done with an empty tracker sets sticky err
    tick(); force_done = 1'b1; settle();
    chk("t6_err_before", 32'(err), 32'd0);
    tick(); force_done = 1'b0; settle();
    chk("t6_err_set", 32'(err), 32'd1);
    repeat (3) tick();
    settle();
    chk("t6_err_sticky", 32'(err), 32'd1);
    tick(); rstd = 1'b0;
    tick(); rstd = 1'b1; settle();
    chk("t6_err_cleared", 32'(err), 32'd0);

    repeat (8) tick();
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
